demux_rr_sched_v: RTL



---
 rtl/demux_rr_sched_v.sv | 91 +++++++++
 1 files changed

// File: rtl/demux_rr_sched_v.sv
// Round-robin burst scheduler that drives the one-hot select of a 1:8 demux.
module demux_rr_sched_v #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [7:0]       i_req,
  output logic [7:0]       o_sel_code,
  output logic [2:0]       o_grant_id,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_burst_cnt
);
  // Purpose: share eight demux outputs among eight requesters, one bounded burst at a time.
  // Latency: request sampled in IDLE at edge k gives a registered one-hot select after edge k.
  // Backpressure: dropping the granted request ends the burst; i_en low only blocks new arbitration.

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_t     state;
  logic [2:0] last;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       win_vld;
  logic       burst_end;

  // Scan from the lowest priority slot (last itself) up to last+1, so the
  // nearest requester after last is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last;
    cand    = last;
    for (int off = 8; off >= 1; off--) begin
      cand = last + 3'(off);
      if (i_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign burst_end = !i_req[o_grant_id] || (o_burst_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      last        <= 3'd7;
      o_sel_code  <= 8'h00;
      o_grant_id  <= 3'd7;
      o_busy      <= 1'b0;
      o_burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_en && win_vld) begin
            state       <= S_GRANT;
            o_sel_code  <= 8'(1) << win_idx;
            o_grant_id  <= win_idx;
            last        <= win_idx;
            o_burst_cnt <= '0;
            o_busy      <= 1'b1;
          end
        end
        S_GRANT: begin
          o_burst_cnt <= o_burst_cnt + CNT_W'(1);
          if (burst_end) begin
            state      <= S_GAP;
            o_sel_code <= 8'h00;
            o_busy     <= 1'b0;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          o_sel_code <= 8'h00;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
